// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - command-driven duty/fade sequencer for a bank of PWM channels
// Optional IRQ block (irq, irq_status, irq_clear) is built when PWM_FADE_IRQ_EN is defined.
module pwm_fade_sequencer #(
    parameter int                   BIT_WIDTH = 8,
    parameter int                   NUM_CH    = 4,
    parameter int                   RATE_W    = 8,
    parameter logic [BIT_WIDTH-1:0] MAX_RESET = {BIT_WIDTH{1'b1}},
    localparam int                  CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [CH_W-1:0]             cmd_ch,
    input  logic [BIT_WIDTH-1:0]        cmd_data,
    input  logic [RATE_W-1:0]           cmd_rate,
    input  logic [NUM_CH*BIT_WIDTH-1:0] pwm_counter,
    output logic [NUM_CH-1:0]           pwm_enable,
    output logic [NUM_CH*BIT_WIDTH-1:0] pwm_duty,
    output logic [BIT_WIDTH-1:0]        pwm_max,
    output logic [NUM_CH-1:0]           ch_busy,
    output logic [NUM_CH-1:0]           fade_done
`ifdef PWM_FADE_IRQ_EN
    ,
    output logic                        irq,
    output logic [NUM_CH-1:0]           irq_status,
    input  logic [NUM_CH-1:0]           irq_clear
`endif
);

    typedef enum logic [1:0] {CH_OFF, CH_HOLD, CH_FADE} ch_state_t;
    typedef enum logic [1:0] {OP_SET = 2'b00, OP_FADE = 2'b01, OP_ENABLE = 2'b10, OP_SET_MAX = 2'b11} op_t;

    localparam logic [CH_W:0]        NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [RATE_W-1:0]    ONE_R    = RATE_W'(1);
    localparam logic [BIT_WIDTH-1:0] ONE_D    = BIT_WIDTH'(1);

    logic                 cmd_pend;
    op_t                  op_r;
    logic [CH_W-1:0]      ch_r;
    logic [BIT_WIDTH-1:0] data_r;
    logic [RATE_W-1:0]    rate_r;
    logic [RATE_W-1:0]    rate_eff;
    logic                 ch_in_range;

    ch_state_t            state_q  [NUM_CH];
    ch_state_t            state_d  [NUM_CH];
    logic [BIT_WIDTH-1:0] duty_q   [NUM_CH];
    logic [BIT_WIDTH-1:0] duty_d   [NUM_CH];
    logic [BIT_WIDTH-1:0] pend_q   [NUM_CH];
    logic [BIT_WIDTH-1:0] pend_d   [NUM_CH];
    logic [BIT_WIDTH-1:0] tgt_q    [NUM_CH];
    logic [BIT_WIDTH-1:0] tgt_d    [NUM_CH];
    logic [BIT_WIDTH-1:0] step_val [NUM_CH];
    logic [RATE_W-1:0]    reload_q [NUM_CH];
    logic [RATE_W-1:0]    reload_d [NUM_CH];
    logic [RATE_W-1:0]    presc_q  [NUM_CH];
    logic [RATE_W-1:0]    presc_d  [NUM_CH];
    logic [NUM_CH-1:0]    pend_vld_q;
    logic [NUM_CH-1:0]    pend_vld_d;
    logic [NUM_CH-1:0]    cmd_hit;
    logic [NUM_CH-1:0]    period_end;
    logic [NUM_CH-1:0]    done_d;
    logic [BIT_WIDTH-1:0] max_d;

    assign cmd_ready   = ~cmd_pend;
    assign rate_eff    = (rate_r == '0) ? ONE_R : rate_r;
    assign ch_in_range = {1'b0, ch_r} < NUM_CH_L;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign pwm_enable[g]                       = (state_q[g] != CH_OFF);
        assign ch_busy[g]                          = (state_q[g] == CH_FADE);
        assign pwm_duty[g*BIT_WIDTH +: BIT_WIDTH]  = duty_q[g];
        assign period_end[g] = pwm_enable[g] && (pwm_counter[g*BIT_WIDTH +: BIT_WIDTH] == pwm_max);
        assign cmd_hit[g]    = cmd_pend && (op_r != OP_SET_MAX) && ch_in_range && (ch_r == CH_W'(g));
        assign step_val[g]   = (tgt_q[g] > duty_q[g]) ? duty_q[g] + ONE_D : duty_q[g] - ONE_D;
    end

    // A command on a channel always overrides that channel's period-end work in the same cycle.
    always_comb begin
        max_d      = pwm_max;
        done_d     = '0;
        pend_vld_d = pend_vld_q;
        if (cmd_pend && op_r == OP_SET_MAX) begin
            max_d = data_r;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            duty_d[i]   = duty_q[i];
            pend_d[i]   = pend_q[i];
            tgt_d[i]    = tgt_q[i];
            reload_d[i] = reload_q[i];
            presc_d[i]  = presc_q[i];
            if (cmd_hit[i]) begin
                case (op_r)
                    OP_SET: begin
                        if (state_q[i] == CH_OFF) begin
                            duty_d[i]     = data_r;
                            pend_vld_d[i] = 1'b0;
                        end else begin
                            pend_d[i]     = data_r;
                            pend_vld_d[i] = 1'b1;
                            state_d[i]    = CH_HOLD;
                        end
                    end
                    OP_FADE: begin
                        tgt_d[i]      = data_r;
                        reload_d[i]   = rate_eff;
                        presc_d[i]    = rate_eff;
                        pend_vld_d[i] = 1'b0;
                        if (data_r == duty_q[i]) begin
                            done_d[i] = 1'b1;
                            if (state_q[i] == CH_FADE) begin
                                state_d[i] = CH_HOLD;
                            end
                        end else begin
                            state_d[i] = CH_FADE;
                        end
                    end
                    OP_ENABLE: begin
                        if (!data_r[0]) begin
                            state_d[i] = CH_OFF;
                        end else if (state_q[i] == CH_OFF) begin
                            state_d[i] = CH_HOLD;
                        end
                    end
                    default: ;
                endcase
            end else if (period_end[i]) begin
                if (pend_vld_q[i]) begin
                    duty_d[i]     = pend_q[i];
                    pend_vld_d[i] = 1'b0;
                end
                if (state_q[i] == CH_FADE) begin
                    if (presc_q[i] <= ONE_R) begin
                        presc_d[i] = reload_q[i];
                        duty_d[i]  = step_val[i];
                        if (step_val[i] == tgt_q[i]) begin
                            state_d[i] = CH_HOLD;
                            done_d[i]  = 1'b1;
                        end
                    end else begin
                        presc_d[i] = presc_q[i] - ONE_R;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_pend   <= 1'b0;
            op_r       <= OP_SET;
            ch_r       <= '0;
            data_r     <= '0;
            rate_r     <= '0;
            pwm_max    <= MAX_RESET;
            fade_done  <= '0;
            pend_vld_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= CH_OFF;
                duty_q[i]   <= '0;
                pend_q[i]   <= '0;
                tgt_q[i]    <= '0;
                reload_q[i] <= '0;
                presc_q[i]  <= '0;
            end
        end else begin
            cmd_pend <= cmd_valid && !cmd_pend;
            if (cmd_valid && !cmd_pend) begin
                op_r   <= op_t'(cmd_op);
                ch_r   <= cmd_ch;
                data_r <= cmd_data;
                rate_r <= cmd_rate;
            end
            pwm_max    <= max_d;
            fade_done  <= done_d;
            pend_vld_q <= pend_vld_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                duty_q[i]   <= duty_d[i];
                pend_q[i]   <= pend_d[i];
                tgt_q[i]    <= tgt_d[i];
                reload_q[i] <= reload_d[i];
                presc_q[i]  <= presc_d[i];
            end
        end
    end

`ifdef PWM_FADE_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | fade_done;
        end
    end

    assign irq = |irq_status;
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - directed self-checking bench for pwm_fade_sequencer
module tb_pwm_fade_sequencer;

    localparam logic [1:0] OP_SET = 2'b00, OP_FADE = 2'b01, OP_ENABLE = 2'b10, OP_SET_MAX = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_ch;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_rate;
    logic [31:0] pwm_counter;
    logic [3:0]  pwm_enable;
    logic [31:0] pwm_duty;
    logic [7:0]  pwm_max;
    logic [3:0]  ch_busy;
    logic [3:0]  fade_done;
`ifdef PWM_FADE_IRQ_EN
    logic        irq;
    logic [3:0]  irq_status;
    logic [3:0]  irq_clear;
    logic        d3_irq;
    logic [2:0]  d3_irq_status;
`endif

    logic        d3_valid;
    logic        d3_ready;
    logic [2:0]  d3_enable;
    logic [23:0] d3_duty;
    logic [7:0]  d3_max;
    logic [2:0]  d3_busy;
    logic [2:0]  d3_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pwm_fade_sequencer #(.BIT_WIDTH(8), .NUM_CH(4), .RATE_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_rate(cmd_rate),
        .pwm_counter(pwm_counter), .pwm_enable(pwm_enable), .pwm_duty(pwm_duty),
        .pwm_max(pwm_max), .ch_busy(ch_busy), .fade_done(fade_done)
`ifdef PWM_FADE_IRQ_EN
        , .irq(irq), .irq_status(irq_status), .irq_clear(irq_clear)
`endif
    );

    // Three-channel instance: cmd_ch == 3 is representable but out of range.
    pwm_fade_sequencer #(.BIT_WIDTH(8), .NUM_CH(3), .RATE_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(d3_valid), .cmd_ready(d3_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_rate(cmd_rate),
        .pwm_counter(24'h0), .pwm_enable(d3_enable), .pwm_duty(d3_duty),
        .pwm_max(d3_max), .ch_busy(d3_busy), .fade_done(d3_done)
`ifdef PWM_FADE_IRQ_EN
        , .irq(d3_irq), .irq_status(d3_irq_status), .irq_clear(3'b000)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  ch;
        logic [7:0]  data;
        logic [7:0]  rate;
        logic [3:0]  en;
        logic [3:0]  busy;
        logic [3:0]  done;
        logic [31:0] duty;
        logic [7:0]  mx;
    } vec_t;

    vec_t vecs [8];

    typedef struct {
        logic [1:0] op;
        logic [1:0] ch;
        logic [7:0] data;
    } bb_t;

    bb_t bb [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] duty_of(input int ch);
        return pwm_duty[ch*8 +: 8];
    endfunction

    // pe_ch >= 0 places a period end of that channel in the execution cycle.
    task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] data,
                        input logic [7:0] rate, input int pe_ch);
        check("ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_data = data; cmd_rate = rate;
        tick();
        cmd_valid = 1'b0;
        check("ready_busy", cmd_ready, 1'b0);
        if (pe_ch >= 0) pwm_counter[pe_ch*8 +: 8] = pwm_max;
        tick();
        pwm_counter = '0;
    endtask

    task automatic period_end(input int ch);
        pwm_counter[ch*8 +: 8] = pwm_max;
        tick();
        pwm_counter = '0;
    endtask

    initial begin
        int done_cnt;

        vecs[0] = '{OP_ENABLE,  2'd0, 8'h01, 8'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0000, 8'hFF};
        vecs[1] = '{OP_SET,     2'd1, 8'h20, 8'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_2000, 8'hFF};
        vecs[2] = '{OP_SET,     2'd0, 8'h40, 8'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_2000, 8'hFF};
        vecs[3] = '{OP_FADE,    2'd2, 8'h00, 8'd3, 4'b0001, 4'b0000, 4'b0100, 32'h0000_2000, 8'hFF};
        vecs[4] = '{OP_FADE,    2'd3, 8'h05, 8'd0, 4'b1001, 4'b1000, 4'b0000, 32'h0000_2000, 8'hFF};
        vecs[5] = '{OP_ENABLE,  2'd3, 8'h00, 8'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_2000, 8'hFF};
        vecs[6] = '{OP_SET_MAX, 2'd2, 8'h0F, 8'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_2000, 8'h0F};
        vecs[7] = '{OP_SET_MAX, 2'd0, 8'hFF, 8'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_2000, 8'hFF};

        bb[0] = '{OP_FADE,    2'd0, 8'h40};
        bb[1] = '{OP_FADE,    2'd0, 8'h40};
        bb[2] = '{OP_SET,     2'd3, 8'h09};
        bb[3] = '{OP_SET_MAX, 2'd1, 8'd200};

        rst_n = 1'b0; cmd_valid = 1'b0; d3_valid = 1'b0;
        cmd_op = '0; cmd_ch = '0; cmd_data = '0; cmd_rate = '0; pwm_counter = '0;
`ifdef PWM_FADE_IRQ_EN
        irq_clear = '0;
`endif
        tick();
        tick();
        check("rst_enable", pwm_enable, 4'b0000);
        check("rst_duty",   pwm_duty,   32'h0);
        check("rst_max",    pwm_max,    8'hFF);
        check("rst_busy",   ch_busy,    4'b0000);
        check("rst_done",   fade_done,  4'b0000);
        check("rst_ready",  cmd_ready,  1'b1);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].op, vecs[v].ch, vecs[v].data, vecs[v].rate, -1);
            check($sformatf("vec%0d_enable", v), pwm_enable, vecs[v].en);
            check($sformatf("vec%0d_busy", v),   ch_busy,    vecs[v].busy);
            check($sformatf("vec%0d_done", v),   fade_done,  vecs[v].done);
            check($sformatf("vec%0d_duty", v),   pwm_duty,   vecs[v].duty);
            check($sformatf("vec%0d_max", v),    pwm_max,    vecs[v].mx);
        end

        // Pending SET on ch0 lands only at its period end.
        pwm_counter[7:0] = 8'd10;
        repeat (3) tick();
        check("set_wait_duty0", duty_of(0), 8'h00);
        pwm_counter[7:0] = 8'd255;
        check("set_edge_duty0_before", duty_of(0), 8'h00);
        tick();
        pwm_counter = '0;
        check("set_edge_duty0_after", duty_of(0), 8'h40);

        // ch1 fade 0 -> 3 at rate 2.
        send(OP_SET, 2'd1, 8'h00, 8'd0, -1);
        check("fade1_start_duty", duty_of(1), 8'h00);
        send(OP_FADE, 2'd1, 8'h03, 8'd2, -1);
        check("fade1_enable", pwm_enable[1], 1'b1);
        check("fade1_busy", ch_busy[1], 1'b1);
        for (int k = 1; k <= 6; k++) begin
            period_end(1);
            check($sformatf("fade1_pe%0d_duty", k), duty_of(1), 8'(k / 2));
            check($sformatf("fade1_pe%0d_busy", k), ch_busy[1], k < 6);
            check($sformatf("fade1_pe%0d_done", k), fade_done[1], k == 6);
        end
        tick();
        check("fade1_done_cleared", fade_done[1], 1'b0);
        check("fade1_hold_duty", duty_of(1), 8'h03);

        // ch2 fade up, reversed after three steps.
        send(OP_FADE, 2'd2, 8'd10, 8'd1, -1);
        for (int k = 1; k <= 3; k++) begin
            period_end(2);
            check($sformatf("fade2_up%0d_duty", k), duty_of(2), 8'(k));
            check($sformatf("fade2_up%0d_done", k), fade_done[2], 1'b0);
        end
        send(OP_FADE, 2'd2, 8'd0, 8'd1, -1);
        check("fade2_retarget_done", fade_done[2], 1'b0);
        check("fade2_retarget_busy", ch_busy[2], 1'b1);
        for (int k = 1; k <= 3; k++) begin
            period_end(2);
            check($sformatf("fade2_dn%0d_duty", k), duty_of(2), 8'(3 - k));
            check($sformatf("fade2_dn%0d_done", k), fade_done[2], k == 3);
        end
        check("fade2_end_busy", ch_busy[2], 1'b0);

        // Back-to-back commands with cmd_valid held high.
        done_cnt = 0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bb_ready%0d", k), cmd_ready, (k % 2) == 0);
            cmd_op = bb[k/2].op; cmd_ch = bb[k/2].ch; cmd_data = bb[k/2].data; cmd_rate = 8'd1;
            tick();
            if (fade_done[0]) done_cnt++;
        end
        cmd_valid = 1'b0;
        tick();
        if (fade_done[0]) done_cnt++;
        check("bb_done0_count", done_cnt, 2);
        check("bb_duty3", duty_of(3), 8'h09);
        check("bb_enable3", pwm_enable[3], 1'b0);
        check("bb_max", pwm_max, 8'd200);
        send(OP_SET_MAX, 2'd0, 8'hFF, 8'd0, -1);

        // Out-of-range channel on the three-channel instance.
        cmd_op = OP_ENABLE; cmd_ch = 2'd3; cmd_data = 8'h01; d3_valid = 1'b1;
        tick();
        d3_valid = 1'b0;
        check("oor_ready_busy", d3_ready, 1'b0);
        tick();
        check("oor_enable", d3_enable, 3'b000);
        check("oor_ready", d3_ready, 1'b1);
        cmd_ch = 2'd2; d3_valid = 1'b1;
        tick();
        d3_valid = 1'b0;
        tick();
        check("inrange_enable", d3_enable, 3'b100);

        // Command collides with a ch3 fade step: the step is dropped.
        send(OP_FADE, 2'd3, 8'd20, 8'd1, -1);
        period_end(3);
        check("coll_pre_duty", duty_of(3), 8'd10);
        send(OP_SET, 2'd3, 8'd30, 8'd0, 3);
        check("coll_duty", duty_of(3), 8'd10);
        check("coll_busy", ch_busy[3], 1'b0);
        check("coll_done", fade_done[3], 1'b0);
        period_end(3);
        check("coll_set_applied", duty_of(3), 8'd30);

        // Reset asserted mid-fade with a command in flight.
        send(OP_FADE, 2'd1, 8'd100, 8'd1, -1);
        period_end(1);
        check("midrst_pre_duty", duty_of(1), 8'd4);
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("midrst_enable", pwm_enable, 4'b0000);
        check("midrst_duty",   pwm_duty,   32'h0);
        check("midrst_busy",   ch_busy,    4'b0000);
        check("midrst_max",    pwm_max,    8'hFF);
        check("midrst_ready",  cmd_ready,  1'b1);
        rst_n = 1'b1;
        tick();

`ifdef PWM_FADE_IRQ_EN
        check("irq_idle", irq, 1'b0);
        send(OP_FADE, 2'd0, 8'd1, 8'd1, -1);
        period_end(0);
        check("irq_done", fade_done[0], 1'b1);
        tick();
        check("irq_set", irq, 1'b1);
        check("irq_status", irq_status, 4'b0001);
        irq_clear = 4'b0001;
        tick();
        irq_clear = 4'b0000;
        check("irq_cleared", irq, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
